// File: rtl/uart_order_server.sv
// uart_order_server
//   UART-side responder to the CPU uart order interface. It accepts one order
//   at a time. A write order serialises 1, 2 or 4 bytes onto a byte-wide TX
//   handshake. A read order assembles 1, 2 or 4 bytes popped from an internal
//   RX byte FIFO. Both directions are little-endian.
//
//   Optional feature macro: UART_SRV_TIMEOUT_EN
//     When defined, a read that waits TIMEOUT_CYCLES with an empty FIFO
//     completes early with the bytes gathered so far (missing bytes are 0).
//     The extra output rx_timeout pulses together with that uart_done.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   uart_order      order request level, held until uart_accepted is seen
//   uart_size       00=4 bytes, 01=2 bytes, 1x=1 byte
//   uart_write      1=write (TX), 0=read (RX)
//   uart_o_data     write data, sampled when the order is latched
//   uart_accepted   one-cycle pulse: order latched
//   uart_done       one-cycle pulse: order complete
//   uart_r_data     read result, updated with uart_done (0 after a write)
//   tx_valid/tx_data/tx_ready   byte stream to the TX engine
//   rx_valid/rx_data            byte pulses from the RX engine (no backpressure)
//   rx_overflow     sticky: a received byte was dropped because the FIFO was full
//   rx_count        RX FIFO occupancy
//   busy            state machine is not IDLE
//   rx_timeout      (UART_SRV_TIMEOUT_EN only) read ended by the timeout
module uart_order_server #(
  parameter int          RX_FIFO_DEPTH  = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             uart_order,
  input  logic [1:0]                       uart_size,
  input  logic                             uart_write,
  input  logic [31:0]                      uart_o_data,
  output logic                             uart_accepted,
  output logic                             uart_done,
  output logic [31:0]                      uart_r_data,
  output logic                             tx_valid,
  output logic [7:0]                       tx_data,
  input  logic                             tx_ready,
  input  logic                             rx_valid,
  input  logic [7:0]                       rx_data,
  output logic                             rx_overflow,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_count,
`ifdef UART_SRV_TIMEOUT_EN
  output logic                             rx_timeout,
`endif
  output logic                             busy
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TX   = 2'd1;
  localparam logic [1:0] S_RX   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    r_size;
  logic          r_write;
  logic [31:0]   r_buf;       // write data to send, or read data being assembled
  logic [1:0]    r_idx;
  logic          r_accepted;
  logic          r_done;
  logic [31:0]   r_rdata;
  logic          r_overflow;

  logic [7:0]    r_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [7:0]    w_pop_data;
  logic [1:0]    w_last_idx;
  logic          w_last;
  logic          w_to_hit;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(RX_FIFO_DEPTH));
  assign w_pop      = (r_state == S_RX) && !w_empty;
  // A full FIFO still takes a byte when the same cycle pops one.
  assign w_push     = rx_valid && (!w_full || w_pop);
  assign w_pop_data = r_mem[r_rd_ptr];
  assign w_last_idx = (r_size == 2'b00) ? 2'd3 : (r_size == 2'b01) ? 2'd1 : 2'd0;
  assign w_last     = (r_idx == w_last_idx);

`ifdef UART_SRV_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_to_flag;
  logic        r_rx_timeout;

  assign w_to_hit   = (r_state == S_RX) && w_empty && (r_to_cnt == TIMEOUT_CYCLES - 32'd1);
  assign rx_timeout = r_rx_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt     <= '0;
      r_to_flag    <= 1'b0;
      r_rx_timeout <= 1'b0;
    end else begin
      r_rx_timeout <= (r_state == S_DONE) && r_to_flag;
      if (r_state != S_RX || w_pop)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 32'd1;
      if (w_to_hit)
        r_to_flag <= 1'b1;
      else if (r_state == S_DONE)
        r_to_flag <= 1'b0;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // FIFO storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (rx_valid && !w_push)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_size     <= '0;
      r_write    <= 1'b0;
      r_buf      <= '0;
      r_idx      <= '0;
      r_accepted <= 1'b0;
      r_done     <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_accepted <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The accepted cycle is spent in IDLE; the request is still high
          // then and must not be latched a second time.
          if (r_accepted) begin
            r_state <= r_write ? S_TX : S_RX;
          end else if (uart_order) begin
            r_size     <= uart_size;
            r_write    <= uart_write;
            r_buf      <= uart_write ? uart_o_data : 32'd0;
            r_idx      <= '0;
            r_accepted <= 1'b1;
          end
        end
        S_TX: begin
          if (tx_ready) begin
            if (w_last) r_state <= S_DONE;
            else        r_idx   <= r_idx + 2'd1;
          end
        end
        S_RX: begin
          if (w_pop) begin
            r_buf[{r_idx, 3'b000} +: 8] <= w_pop_data;
            if (w_last) r_state <= S_DONE;
            else        r_idx   <= r_idx + 2'd1;
          end else if (w_to_hit) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_done  <= 1'b1;
          r_rdata <= r_write ? 32'd0 : r_buf;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign uart_accepted = r_accepted;
  assign uart_done     = r_done;
  assign uart_r_data   = r_rdata;
  assign tx_valid      = (r_state == S_TX);
  assign tx_data       = r_buf[{r_idx, 3'b000} +: 8];
  assign rx_overflow   = r_overflow;
  assign rx_count      = r_count;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_order_server.sv
module tb_uart_order_server;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_order = 1'b0;
  logic [1:0]    uart_size = 2'b00;
  logic          uart_write = 1'b0;
  logic [31:0]   uart_o_data = '0;
  logic          uart_accepted;
  logic          uart_done;
  logic [31:0]   uart_r_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_overflow;
  logic [$clog2(D):0] rx_count;
  logic          busy;
`ifdef UART_SRV_TIMEOUT_EN
  logic          rx_timeout;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_done[$];

  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic [7:0]  e8;
  logic [31:0] e32;

  uart_order_server #(.RX_FIFO_DEPTH(D), .TIMEOUT_CYCLES(32'd1000)) dut (
    .clk(clk), .rst(rst),
    .uart_order(uart_order), .uart_size(uart_size), .uart_write(uart_write),
    .uart_o_data(uart_o_data), .uart_accepted(uart_accepted), .uart_done(uart_done),
    .uart_r_data(uart_r_data), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_overflow(rx_overflow), .rx_count(rx_count),
`ifdef UART_SRV_TIMEOUT_EN
    .rx_timeout(rx_timeout),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: TX handshakes and done pulses are compared against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && tx_valid) begin
        checks++;
        if (tx_data !== prev_data) begin
          errors++;
          $display("FAIL tx_stable: tx_data=%02h required %02h", tx_data, prev_data);
        end
      end
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: tx_data=%02h with no byte expected", tx_data);
        end else begin
          e8 = exp_tx.pop_front();
          $display("tx byte=%02h expected=%02h", tx_data, e8);
          if (tx_data !== e8) begin
            errors++;
            $display("FAIL tx_byte: got %02h required %02h", tx_data, e8);
          end
        end
      end
      if (uart_done) begin
        done_cnt++;
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: r_data=%08h with no done expected", uart_r_data);
        end else begin
          e32 = exp_done.pop_front();
          $display("done r_data=%08h expected=%08h", uart_r_data, e32);
          if (uart_r_data !== e32) begin
            errors++;
            $display("FAIL done_rdata: got %08h required %08h", uart_r_data, e32);
          end
        end
      end
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  task automatic push_rx(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Raise an order and drop it once accepted is seen (bounded wait).
  task automatic issue_order(input logic [1:0] sz, input logic wr, input logic [31:0] d);
    bit seen = 0;
    @(posedge clk); #1;
    uart_order = 1'b1; uart_size = sz; uart_write = wr; uart_o_data = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (uart_accepted) seen = 1;
    end
    uart_order = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL accept_timeout: accepted=0 required 1 within 20 cycles");
    end
  endtask

  task automatic wait_done(input int start, input int max_cycles);
    bit seen = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(posedge clk); #1;
      if (done_cnt != start) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", max_cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({uart_accepted, uart_done, tx_valid, rx_overflow, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: acc/done/txv/ovf/busy=%05b required 00000",
               {uart_accepted, uart_done, tx_valid, rx_overflow, busy});
    end
    checks++;
    if (uart_r_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %08h required 00000000", uart_r_data);
    end
    checks++;
    if (rx_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d required 0", rx_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_byte();
    int d0 = done_cnt;
    tx_ready = 1'b1;
    exp_tx.push_back(8'haa);
    exp_done.push_back(32'd0);
    @(posedge clk); #1;
    uart_order = 1'b1; uart_size = 2'b10; uart_write = 1'b1; uart_o_data = 32'haa;
    @(negedge clk);           // before the latching edge
    @(negedge clk);           // one cycle after the order edge
    uart_order = 1'b0;
    checks++;
    if (uart_accepted !== 1'b1) begin
      errors++;
      $display("FAIL wr1_accept: accepted=%b required 1", uart_accepted);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'haa) begin
      errors++;
      $display("FAIL wr1_tx: valid=%b data=%02h required 1/aa", tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if (uart_done !== 1'b0) begin
      errors++;
      $display("FAIL wr1_early_done: done=%b required 0", uart_done);
    end
    @(negedge clk);
    checks++;
    if (uart_done !== 1'b1) begin
      errors++;
      $display("FAIL wr1_done: done=%b required 1", uart_done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL wr1_done_count: got %0d required %0d", done_cnt - d0, 1);
    end
  endtask

  task automatic test_word_write();
    int d0 = done_cnt;
    exp_tx.push_back(8'h44); exp_tx.push_back(8'h33);
    exp_tx.push_back(8'h22); exp_tx.push_back(8'h11);
    exp_done.push_back(32'd0);
    tx_ready = 1'b0;
    fork
      issue_order(2'b00, 1'b1, 32'h11223344);
      begin
        for (int i = 0; i < 60 && done_cnt == d0; i++) begin
          @(posedge clk); #1;
          tx_ready = ~tx_ready;
        end
      end
    join
    wait_done(d0, 60);
    tx_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL word_done_count: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_read_prebuffered();
    int d0 = done_cnt;
    push_rx(8'hef); push_rx(8'hbe); push_rx(8'had); push_rx(8'hde);
    @(negedge clk);
    checks++;
    if (rx_count !== 5'd4) begin
      errors++;
      $display("FAIL pre_count: got %0d required 4", rx_count);
    end
    exp_done.push_back(32'hdeadbeef);
    issue_order(2'b00, 1'b0, 32'h0);
    wait_done(d0, 30);
    checks++;
    if (rx_count !== 5'd0) begin
      errors++;
      $display("FAIL pre_drain: got %0d required 0", rx_count);
    end
  endtask

  task automatic test_read_late();
    int d0 = done_cnt;
    exp_done.push_back(32'h00001234);
    issue_order(2'b01, 1'b0, 32'hffffffff);
    push_rx(8'h34);
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL late_early_done: got %0d dones required 0", done_cnt - d0);
    end
    push_rx(8'h12);
    wait_done(d0, 20);
  endtask

  task automatic test_overflow();
    int d0 = done_cnt;
    for (int i = 0; i <= D; i++) push_rx(8'(8'h50 + i));
    @(negedge clk);
    checks++;
    if (rx_count !== 5'(D) || rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_state: count=%0d ovf=%b required %0d/1", rx_count, rx_overflow, D);
    end
    exp_done.push_back(32'h53525150);
    issue_order(2'b00, 1'b0, 32'h0);
    wait_done(d0, 30);
    checks++;
    if (rx_count !== 5'(D - 4) || rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after: count=%0d ovf=%b required %0d/1", rx_count, rx_overflow, D - 4);
    end
  endtask

  task automatic test_reset_mid_tx();
    int d0;
    exp_tx.push_back(8'h0d);
    issue_order(2'b00, 1'b1, 32'hcafef00d);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || rx_count !== '0 || rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b txv=%b count=%0d ovf=%b required 0/0/0/0",
               busy, tx_valid, rx_count, rx_overflow);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d dones required 0", done_cnt - d0);
    end
    tx_ready = 1'b1;
    exp_tx.push_back(8'h5a);
    exp_done.push_back(32'd0);
    issue_order(2'b10, 1'b1, 32'h0000005a);
    wait_done(d0, 20);
    tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_byte();
    test_word_write();
    test_read_prebuffered();
    test_read_late();
    test_overflow();
    test_reset_mid_tx();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_tx.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL leftover: tx=%0d done=%0d expectations unconsumed required 0/0",
               exp_tx.size(), exp_done.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_order_server.md
Name: uart_order_server

Overview:
- UART-side responder to the CPU's uart order interface (order/size/write/o_data in; accepted/done/r_data out).
- Accepts one order at a time and serialises write data onto a byte-wide TX stream.
- Assembles read data from a byte-wide RX stream, buffered in an internal RX FIFO.
- Sits between the cpu/io order mux and the physical uart_tx/uart_rx byte engines.

Parameters:
- RX_FIFO_DEPTH, 16, RX byte FIFO entries; must be a power of two, at least 2.
- TIMEOUT_CYCLES, 32'd100000000, read-byte wait limit; used only with UART_SRV_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- uart_order  in  1  order request; level, held by initiator until accepted seen
- uart_size  in  2  00=4 bytes, 01=2 bytes, 10=1 byte, 11=1 byte
- uart_write  in  1  1=write (TX), 0=read (RX)
- uart_o_data  in  32  write data; sampled at accept
- uart_accepted  out  1  one-cycle pulse: order latched
- uart_done  out  1  one-cycle pulse: order complete
- uart_r_data  out  32  read result; valid on done, held until next done
- tx_valid  out  1  TX byte valid
- tx_data  out  8  TX byte
- tx_ready  in  1  TX engine accepts byte when tx_valid&tx_ready
- rx_valid  in  1  one-cycle pulse per received byte; no backpressure
- rx_data  in  8  received byte
- rx_overflow  out  1  sticky: byte dropped because FIFO full
- rx_count  out  $clog2(RX_FIFO_DEPTH)+1  FIFO occupancy
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO emptied; all outputs 0, including uart_r_data and rx_overflow.
- Byte count N from uart_size: 4, 2, 1, 1. Byte order is little-endian both ways: byte k maps to bits [8k+7:8k].
- States: IDLE, TX, RX, DONE.
- IDLE:
  - uart_order=1 at an edge latches size, write, o_data, clears byte index.
  - Next cycle: uart_accepted=1 for exactly one cycle; state goes to TX (write) or RX (read).
  - Initiator drops uart_order on seeing accepted. Order re-raised later is a new order.
- TX:
  - tx_valid=1 and tx_data=byte[index] while in TX.
  - On tx_valid&tx_ready: index++. Last byte accepted -> DONE. tx_data is stable while tx_valid & ~tx_ready.
- RX:
  - When FIFO non-empty, pop one byte per cycle into byte[index], index++. Last byte popped -> DONE.
  - Unused upper bytes are zero (size 10: r_data={24'b0,b0}).
- DONE:
  - uart_done=1 for one cycle, then IDLE.
  - Read: uart_r_data updated this cycle. Write: uart_r_data=0.
  - Minimum order latency, write N=1 with tx_ready=1: order edge -> accepted +1 -> TX +1 -> done +2.
- RX FIFO:
  - Pushes on rx_valid in every state, so bytes arriving with no read pending are kept.
  - Simultaneous push and pop: both occur, count unchanged.
  - Push when full, without a same-cycle pop: byte dropped, rx_overflow set until reset.
  - Pointers wrap modulo RX_FIFO_DEPTH.
- Reset mid-order: order abandoned; no done emitted; FIFO contents lost.
- uart_order while not IDLE: ignored, not accepted until IDLE.

Optional Feature:
- UART_SRV_TIMEOUT_EN defined:
  - A 32-bit counter clears on each pop in RX and counts while in RX with the FIFO empty.
  - On reaching TIMEOUT_CYCLES: go to DONE with the partially assembled data (missing bytes 0).
  - Extra output rx_timeout (1 bit) pulses with that uart_done.
- UART_SRV_TIMEOUT_EN undefined: RX waits indefinitely; rx_timeout port absent.

Test Plan:
- Write: size=10, write=1, o_data=32'haa, tx_ready=1 -> accepted 1 cycle later; single tx byte 8'haa; done pulse; r_data=0.
- Word write: size=00, o_data=32'h11223344, tx_ready toggling 1/0 -> tx bytes 44,33,22,11 in order; tx_data stable while stalled; one done.
- Read, pre-buffered: push 8'hef,be,ad,de while idle (rx_count=4); size=00 read -> r_data=32'hdeadbeef at done; rx_count=0.
- Read before data: size=01 read, bytes 8'h34, 8'h12 arrive 50 cycles apart -> done after second byte; r_data=32'h00001234.
- Overflow: push RX_FIFO_DEPTH+1 bytes with no read -> rx_count=16, rx_overflow=1; a 4-byte read returns the first four bytes.
- Reset mid-TX: rst pulse after the first byte of a word write -> busy=0, tx_valid=0, no done; the next order proceeds normally.
